// File: rtl/seq_alu_if.sv
// Handshake and operand/result bundle for seq_alu.
// The master issues operations; the slave (the ALU) returns busy/done/result.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 6
);
  logic                   start_in;
  logic [1:0]             op_in;
  logic [WIDTH-1:0]       a_in;
  logic [WIDTH-1:0]       b_in;
  logic                   busy_out;
  logic                   done_out;
  logic [2*WIDTH-1:0]     c_out;
  logic                   overflow;

  modport master (
    output start_in, op_in, a_in, b_in,
    input  busy_out, done_out, c_out, overflow
  );

  modport slave (
    input  start_in, op_in, a_in, b_in,
    output busy_out, done_out, c_out, overflow
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle signed add/sub, shift-add signed multiply and
// restoring unsigned divide, one bit per clock, behind a start/busy/done handshake.
module seq_alu #(
  parameter int unsigned WIDTH = 6
) (
  input logic      clk_in,
  input logic      rst_in,
  seq_alu_if.slave bus
);
  localparam int unsigned RES_W = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_q, neg_d;
  logic [RES_W-1:0] c_q, c_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             is_sub;
  logic [WIDTH-1:0] as_b, as_sum;
  logic             as_ovf;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [RES_W-1:0] mul_next, mul_prod;
  logic [WIDTH:0]   mul_top;
  logic             mul_ovf;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [RES_W-1:0] div_next;

  assign accept = bus.start_in && !busy_q;

  // Subtract is a + ~b + 1, so one overflow rule covers both.
  assign is_sub = (bus.op_in == OP_SUB);
  assign as_b   = is_sub ? ~bus.b_in : bus.b_in;
  assign as_sum = bus.a_in + as_b + WIDTH'(is_sub);
  assign as_ovf = (bus.a_in[WIDTH-1] == as_b[WIDTH-1]) &&
                  (as_sum[WIDTH-1] != bus.a_in[WIDTH-1]);

  // Magnitudes are unsigned WIDTH-bit, so the most-negative operand still fits.
  assign mag_a = bus.a_in[WIDTH-1] ? (~bus.a_in + WIDTH'(1)) : bus.a_in;
  assign mag_b = bus.b_in[WIDTH-1] ? (~bus.b_in + WIDTH'(1)) : bus.b_in;

  // acc = {partial high, multiplier low}; add multiplicand then shift right.
  assign mul_sum  = {1'b0, acc_q[RES_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = RES_W'({mul_sum, acc_q[WIDTH-1:0]} >> 1);
  assign mul_prod = neg_q ? (~mul_next + RES_W'(1)) : mul_next;
  assign mul_top  = mul_prod[RES_W-1:WIDTH-1];
  assign mul_ovf  = !((&mul_top) || !(|mul_top));

  // acc = {remainder, dividend/quotient}; a zero divisor naturally yields q=all ones, r=a.
  assign div_shift = {acc_q[RES_W-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_rem   = WIDTH'(div_shift - {1'b0, opnd_q});
  assign div_next  = div_ge ? {div_rem, acc_q[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && bus.op_in == OP_MUL)      state_d = ST_MUL;
        else if (accept && bus.op_in == OP_DIV) state_d = ST_DIV;
      end
      ST_MUL, ST_DIV: if (cnt_q == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    neg_d  = neg_q;
    c_d    = c_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    busy_d = (state_d != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (accept && bus.op_in[1]) begin
          cnt_d  = CNT_W'(WIDTH - 1);
          opnd_d = (bus.op_in == OP_MUL) ? mag_a : bus.b_in;
          acc_d  = (bus.op_in == OP_MUL) ? {WIDTH'(0), mag_b} : {WIDTH'(0), bus.a_in};
          neg_d  = (bus.op_in == OP_MUL) && (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
        end else if (accept) begin
          c_d    = {{WIDTH{as_sum[WIDTH-1]}}, as_sum};
          ovf_d  = as_ovf;
          done_d = 1'b1;
        end
      end
      ST_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          c_d    = mul_prod;
          ovf_d  = mul_ovf;
          done_d = 1'b1;
        end
      end
      ST_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          c_d    = div_next;
          ovf_d  = (opnd_q == '0);
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      neg_q  <= 1'b0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      neg_q  <= neg_d;
      c_q    <= c_d;
      ovf_q  <= ovf_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.busy_out = busy_q;
  assign bus.done_out = done_q;
  assign bus.c_out    = c_q;
  assign bus.overflow = ovf_q;
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor of the 6-bit combinational ALU. It performs signed add, subtract and multiply and unsigned divide on WIDTH-bit operands. A start/busy/done handshake lets the surrounding datapath issue one operation at a time. Add and subtract complete in one cycle; multiply (shift-add) and divide (restoring) each iterate one bit per clock, so the block scales to wide operands without a large combinational array.

## Interface
- WIDTH, 6, operand width in bits (must be ≥ 2); result width is 2*WIDTH.
- clk_in  input  1  clock; all state changes on its rising edge.
- rst_in  input  1  reset; synchronous and active-high.
- start_in  input  1  request; sampled only when busy_out=0.
- op_in  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- busy_out  output  1  operation in progress; further starts are ignored.
- done_out  output  1  one-cycle pulse; c_out/overflow are valid from this cycle.
- c_out  output  2*WIDTH  result, held until the next completion.
- overflow  output  1  overflow / divide-by-zero flag, held with c_out.

## Operation
- States: IDLE, MUL, DIV.
  - IDLE → MUL/DIV on an accepted start with op 10/11.
  - MUL/DIV → IDLE when the step counter expires.
  - Add and subtract never leave IDLE.
- Accepted start: start_in=1 while busy_out=0. a_in, b_in and op_in are latched at that edge. Operand changes afterwards have no effect.
- Add: c_out = sign-extended WIDTH-bit sum (wraps). overflow = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]).
- Sub: computed as a + ~b + 1, with sign extension as for add. overflow = (a[W-1]!=b[W-1]) && (diff[W-1]!=a[W-1]).
- Mul, signed:
  - Product of magnitudes is formed by WIDTH shift-add steps.
  - The result is negated if the operand signs differ, giving the full 2*WIDTH two's-complement product.
  - overflow = 1 iff the product is outside [-2^(W-1), 2^(W-1)-1].
  - The most-negative operand is handled: its magnitude 2^(W-1) needs WIDTH bits unsigned.
- Div, unsigned, restoring: WIDTH steps. c_out = {remainder, quotient}. overflow = 0.
- Div by zero (b=0): quotient = all ones, remainder = a, overflow = 1. Still takes the full WIDTH steps.
- Reset outputs: c_out=0, overflow=0, busy_out=0, done_out=0, state=IDLE. Internal counter and working registers are cleared.
- Reset mid-operation aborts it. No done_out is produced, and c_out/overflow return to 0.
- start_in while busy_out=1: ignored. Nothing is queued, and the in-flight result is unaffected.

## Timing
- Accept edge = edge k.
- Add/sub:
  - Result registered at edge k.
  - done_out=1 during cycle k..k+1.
  - busy_out never asserts.
- Mul/div:
  - busy_out=1 from edge k to edge k+WIDTH.
  - Result registered, busy_out←0 and done_out←1 at edge k+WIDTH.
  - Latency is WIDTH cycles.
- done_out is high for exactly one cycle per accepted op.
- Back-to-back: a start in the done_out cycle is accepted; for add/sub this means every cycle. done_out stays high for consecutive completions.
- c_out/overflow change only at a completion edge or at reset.

## Test plan
- WIDTH=6, after reset: c_out=0, overflow=0, busy=0, done=0. Add 31+1 → done 1 cycle later, c_out=12'hFE0, overflow=1. Sub -32-1 → c_out=12'h01F, overflow=1.
- Mul -5*7 → busy for 6 cycles, done at edge k+6, c_out=12'hFDD, overflow=1. Mul 3*-4 → c_out=12'hFF4, overflow=0. Mul -32*-1 → c_out=12'h020, overflow=1.
- Div 45/7 → c_out=12'h0C6 (r=3, q=6), overflow=0. Div 13/0 → c_out=12'h37F, overflow=1.
- Issue mul, then pulse start_in with a different div mid-flight and change a_in/b_in → only the mul result appears, with one done pulse. A start in the done cycle is accepted.
- Assert rst_in at step 3 of a div → next cycle busy=0, done=0, c_out=0. No later done pulse. A fresh add then completes normally.
- Randomised ops at WIDTH=6 and WIDTH=16 against a reference model: c_out, overflow and latency (1 or WIDTH) match for all ops.
